// File: rtl/if_fetch_unit.sv
//==============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage: PC owner, SPM port-A driver and
//               external-bus fetcher delivering {if_pc, if_insn, if_en}.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_fetch_unit #(
    parameter int                ADDR_W       = 30,
    parameter int                DATA_W       = 32,
    parameter int                SPM_ADDR_W   = 12,
    parameter int                TAG_W        = 3,
    parameter logic [TAG_W-1:0]  SPM_TAG      = 3'd1,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 30'h0800_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     new_pc,
    output logic [SPM_ADDR_W-1:0] if_spm_addr,
    output logic                  if_spm_as_,
    output logic                  if_spm_rw,
    output logic [DATA_W-1:0]     if_spm_wr_data,
    input  logic [DATA_W-1:0]     if_spm_rd_data,
    output logic                  if_bus_req_,
    input  logic                  if_bus_grnt_,
    output logic [ADDR_W-1:0]     if_bus_addr,
    output logic                  if_bus_as_,
    output logic                  if_bus_rw,
    input  logic                  if_bus_rdy_,
    input  logic [DATA_W-1:0]     if_bus_rd_data,
    output logic [ADDR_W-1:0]     if_pc,
    output logic [DATA_W-1:0]     if_insn,
    output logic                  if_en,
    output logic                  busy
);

    localparam logic              c_read   = 1'b1;
    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   q1_pc_q,    q1_pc_d;
    logic                q1_valid_q, q1_valid_d;
    logic [ADDR_W-1:0]   if_pc_q,    if_pc_d;
    logic [DATA_W-1:0]   if_insn_q,  if_insn_d;
    logic                if_en_q,    if_en_d;
    logic [DATA_W-1:0]   bus_buf_q,  bus_buf_d;

    logic w_pc_in_spm;
    logic w_spm_issue;
    logic w_spm_replay;

    assign w_pc_in_spm  = (fetch_pc_q[ADDR_W-1 -: TAG_W] == SPM_TAG);
    assign w_spm_issue  = !reset && !flush && !stall && w_pc_in_spm && (state_q == S_IDLE);
    // While stalled, re-address the in-flight word so the RAM output keeps it.
    assign w_spm_replay = !reset && !flush && stall && q1_valid_q;

    assign if_spm_addr    = w_spm_replay ? q1_pc_q[SPM_ADDR_W-1:0] : fetch_pc_q[SPM_ADDR_W-1:0];
    assign if_spm_as_     = !(w_spm_issue || w_spm_replay);
    assign if_spm_rw      = c_read;
    assign if_spm_wr_data = '0;

    assign if_bus_req_ = reset || !((state_q == S_REQ) || (state_q == S_ACCESS));
    assign if_bus_as_  = reset || (state_q != S_ACCESS);
    assign if_bus_addr = fetch_pc_q;
    assign if_bus_rw   = c_read;
    assign busy        = (state_q != S_IDLE);

    assign if_pc   = if_pc_q;
    assign if_insn = if_insn_q;
    assign if_en   = if_en_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q1_pc_d    = q1_pc_q;
        q1_valid_d = q1_valid_q;
        if_pc_d    = if_pc_q;
        if_insn_d  = if_insn_q;
        if_en_d    = if_en_q;
        bus_buf_d  = bus_buf_q;

        if (flush) begin
            fetch_pc_d = new_pc;
            q1_valid_d = 1'b0;
            if_en_d    = 1'b0;
            state_d    = S_IDLE;
        end else if (!stall) begin
            if_en_d    = 1'b0;
            q1_valid_d = 1'b0;
            if (q1_valid_q) begin
                if_pc_d   = q1_pc_q;
                if_insn_d = if_spm_rd_data;
                if_en_d   = 1'b1;
            end
            if (w_spm_issue) begin
                q1_pc_d    = fetch_pc_q;
                q1_valid_d = 1'b1;
                fetch_pc_d = fetch_pc_q + c_pc_one;
            end
            case (state_q)
                // Bus fetch starts only once the SPM pipeline has drained.
                S_IDLE: begin
                    if (!w_pc_in_spm && !q1_valid_q) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (!if_bus_grnt_) begin
                        state_d = S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!if_bus_rdy_) begin
                        if_pc_d    = fetch_pc_q;
                        if_insn_d  = if_bus_rd_data;
                        if_en_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + c_pc_one;
                        state_d    = S_IDLE;
                    end
                end
                S_DONE: begin
                    if_pc_d    = fetch_pc_q;
                    if_insn_d  = bus_buf_q;
                    if_en_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + c_pc_one;
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            // Stalled: outputs frozen, but the bus handshake keeps running.
            case (state_q)
                S_REQ: begin
                    if (!if_bus_grnt_) begin
                        state_d = S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!if_bus_rdy_) begin
                        bus_buf_d = if_bus_rd_data;
                        state_d   = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_VECTOR;
            q1_pc_q    <= '0;
            q1_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_insn_q  <= '0;
            if_en_q    <= 1'b0;
            bus_buf_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            q1_pc_q    <= q1_pc_d;
            q1_valid_q <= q1_valid_d;
            if_pc_q    <= if_pc_d;
            if_insn_q  <= if_insn_d;
            if_en_q    <= if_en_d;
            bus_buf_q  <= bus_buf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
//==============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit: vector table, directed
//               bus/flush/stall/reset sequences and a random stream scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_if_fetch_unit;

    localparam logic [29:0] RV = 30'h0800_0000;
    localparam int          NV = 16;
    localparam int          WATCHDOG = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] new_pc = '0;
    logic [11:0] if_spm_addr;
    logic        if_spm_as_, if_spm_rw;
    logic [31:0] if_spm_wr_data;
    logic [31:0] if_spm_rd_data = '0;
    logic        if_bus_req_, if_bus_as_, if_bus_rw;
    logic        if_bus_grnt_ = 1'b1;
    logic        if_bus_rdy_ = 1'b1;
    logic [31:0] if_bus_rd_data = '0;
    logic [29:0] if_bus_addr, if_pc;
    logic [31:0] if_insn;
    logic        if_en, busy;

    int n_checks = 0;
    int n_fail = 0;
    int gnt_delay = 2;
    int rdy_delay = 3;
    bit inject = 1'b0;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .if_spm_addr(if_spm_addr), .if_spm_as_(if_spm_as_), .if_spm_rw(if_spm_rw),
        .if_spm_wr_data(if_spm_wr_data), .if_spm_rd_data(if_spm_rd_data),
        .if_bus_req_(if_bus_req_), .if_bus_grnt_(if_bus_grnt_), .if_bus_addr(if_bus_addr),
        .if_bus_as_(if_bus_as_), .if_bus_rw(if_bus_rw), .if_bus_rdy_(if_bus_rdy_),
        .if_bus_rd_data(if_bus_rd_data), .if_pc(if_pc), .if_insn(if_insn),
        .if_en(if_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the program: SPM word k and bus word at address a.
    function automatic logic is_spm(input logic [29:0] a);
        return a[29:27] == 3'd1;
    endfunction

    function automatic logic [31:0] bus_word(input logic [29:0] a);
        if (a == 30'h1000_0000) return 32'hDEAD_BEEF;
        return 32'h5A00_0000 ^ {2'b00, a};
    endfunction

    function automatic logic [31:0] ref_insn(input logic [29:0] a);
        return is_spm(a) ? (32'hA000_0000 + {20'd0, a[11:0]}) : bus_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-read SPM model.
    always @(posedge clk) begin
        if (!if_spm_as_) if_spm_rd_data <= 32'hA000_0000 + {20'd0, if_spm_addr};
    end

    // Bus slave: grant gnt_delay cycles after req_, ready rdy_delay cycles after as_.
    int gcnt = 0;
    int rcnt = 0;
    always @(negedge clk) begin
        if (if_bus_req_) begin
            gcnt = 0;
            if_bus_grnt_ = 1'b1;
        end else begin
            if (gcnt >= gnt_delay) if_bus_grnt_ = 1'b0;
            gcnt++;
        end
        if (inject) begin
            if_bus_rdy_ = 1'b0;
            if_bus_rd_data = 32'hBAD0_BAD0;
        end else if (if_bus_as_) begin
            rcnt = 0;
            if_bus_rdy_ = 1'b1;
        end else begin
            rcnt++;
            if (rcnt >= rdy_delay) begin
                if_bus_rdy_ = 1'b0;
                if_bus_rd_data = bus_word(if_bus_addr);
            end
        end
    end

    // Stream scoreboard: between redirects the delivered PCs are consecutive and
    // each carries the memory word at that PC; stalls freeze the outputs.
    logic        e_reset = 1'b1, e_stall = 1'b0, e_flush = 1'b0;
    logic [29:0] e_new_pc = '0;
    logic [29:0] exp_pc = RV;
    logic [29:0] p_pc = '0;
    logic [31:0] p_insn = '0;
    logic        p_en = 1'b0;
    int          gap = 0;

    always @(negedge clk) begin
        if (e_reset) begin
            check("sb_reset_out", 64'({if_en, if_pc, if_insn, busy}), 64'(0));
            exp_pc = RV;
            gap = 0;
        end else if (e_flush) begin
            check("sb_flush_en", 64'(if_en), 64'(0));
            exp_pc = e_new_pc;
            gap = 0;
        end else if (e_stall) begin
            check("sb_stall_hold", 64'({if_en, if_pc, if_insn}), 64'({p_en, p_pc, p_insn}));
        end else if (if_en) begin
            check("sb_stream_pc", 64'(if_pc), 64'(exp_pc));
            check("sb_stream_insn", 64'(if_insn), 64'(ref_insn(exp_pc)));
            exp_pc = exp_pc + 30'd1;
            gap = 0;
        end else begin
            gap++;
            if (gap == WATCHDOG) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_watchdog: no delivery for %0d cycles, expected pc %0h", gap, exp_pc);
            end
        end
        p_pc = if_pc;
        p_insn = if_insn;
        p_en = if_en;
        e_reset = reset;
        e_stall = stall;
        e_flush = flush;
        e_new_pc = new_pc;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [29:0] npc;
        logic        en;
        logic [29:0] pc;
        logic [31:0] insn;
    } vec_t;

    vec_t tbl [NV];

    function automatic void set_row(input int i, input logic r, input logic s, input logic f,
                                    input logic [29:0] np, input logic e, input logic [29:0] p);
        tbl[i].rst = r;
        tbl[i].stall = s;
        tbl[i].flush = f;
        tbl[i].npc = np;
        tbl[i].en = e;
        tbl[i].pc = p;
        tbl[i].insn = r ? 32'd0 : ref_insn(p);
    endfunction

    task automatic check_row(input int i);
        check($sformatf("vec%0d_en", i), 64'(if_en), 64'(tbl[i].en));
        if (tbl[i].en || tbl[i].rst) begin
            check($sformatf("vec%0d_pc", i), 64'(if_pc), 64'(tbl[i].pc));
            check($sformatf("vec%0d_insn", i), 64'(if_insn), 64'(tbl[i].insn));
        end
    endtask

    function automatic logic [29:0] pick_target();
        case ($urandom_range(0, 4))
            0: return RV + 30'($urandom_range(0, 4095));
            1: return 30'h0FFF_FFF0 + 30'($urandom_range(0, 15));
            2: return 30'h07FF_FFFC + 30'($urandom_range(0, 3));
            3: return 30'h3FFF_FFFE;
            default: return 30'h1000_0000 + 30'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int cyc;
        // Reset, SPM stream, 3-cycle stall with pc 5 in flight, flush to SPM target.
        set_row(0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0);
        set_row(1, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0);
        for (int i = 2; i <= 6; i++) set_row(i, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, RV + 30'(i - 2));
        for (int i = 7; i <= 9; i++) set_row(i, 1'b0, 1'b1, 1'b0, 30'h0, 1'b1, RV + 30'd4);
        set_row(10, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, RV + 30'd5);
        set_row(11, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, RV + 30'd6);
        set_row(12, 1'b0, 1'b0, 1'b1, 30'h0800_0100, 1'b0, 30'h0);
        set_row(13, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0);
        set_row(14, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 30'h0800_0100);
        set_row(15, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 30'h0800_0101);

        for (int i = 0; i < NV; i++) begin
            tick();
            if (i > 0) check_row(i - 1);
            reset = tbl[i].rst;
            stall = tbl[i].stall;
            flush = tbl[i].flush;
            new_pc = tbl[i].npc;
        end
        tick();
        check_row(NV - 1);
        flush = 1'b0;
        stall = 1'b0;

        // Bus fetch of 0xDEAD_BEEF at 0x1000_0000.
        gnt_delay = 2;
        rdy_delay = 3;
        flush = 1'b1;
        new_pc = 30'h1000_0000;
        tick();
        flush = 1'b0;
        cyc = 0;
        while (!busy && cyc < 10) begin tick(); cyc++; end
        check("t4_busy_start", 64'(busy), 64'(1));
        cyc = 0;
        while (!if_en && cyc < 30) begin
            check("t4_busy_hold", 64'(busy), 64'(1));
            tick();
            cyc++;
        end
        check("t4_en", 64'(if_en), 64'(1));
        check("t4_pc", 64'(if_pc), 64'(30'h1000_0000));
        check("t4_insn", 64'(if_insn), 64'(32'hDEAD_BEEF));
        check("t4_strobes_off", 64'({if_bus_req_, if_bus_as_}), 64'(2'b11));
        tick();
        check("t4_single_pulse", 64'(if_en), 64'(0));

        // Flush during ACCESS; late ready data must be ignored.
        rdy_delay = 6;
        cyc = 0;
        while (if_bus_as_ && cyc < 30) begin tick(); cyc++; end
        check("t5_in_access", 64'(if_bus_as_), 64'(0));
        flush = 1'b1;
        new_pc = 30'h0800_0200;
        tick();
        flush = 1'b0;
        inject = 1'b1;
        check("t5_strobes_off", 64'({if_bus_req_, if_bus_as_, busy}), 64'(3'b110));
        tick();
        tick();
        inject = 1'b0;
        check("t5_en", 64'(if_en), 64'(1));
        check("t5_pc", 64'(if_pc), 64'(30'h0800_0200));
        check("t5_insn", 64'(if_insn), 64'(32'hA000_0200));

        // Ready while stalled: data parked until stall drops.
        rdy_delay = 2;
        flush = 1'b1;
        new_pc = 30'h1000_0040;
        tick();
        flush = 1'b0;
        cyc = 0;
        while (if_bus_as_ && cyc < 30) begin tick(); cyc++; end
        check("t6_in_access", 64'(if_bus_as_), 64'(0));
        stall = 1'b1;
        cyc = 0;
        while (!if_bus_as_ && cyc < 20) begin tick(); cyc++; end
        for (int k = 0; k < 3; k++) begin
            check("t6_done_state", 64'({busy, if_bus_req_, if_bus_as_, if_en}), 64'(4'b1110));
            tick();
        end
        stall = 1'b0;
        tick();
        check("t6_en", 64'(if_en), 64'(1));
        check("t6_pc", 64'(if_pc), 64'(30'h1000_0040));
        check("t6_insn", 64'(if_insn), 64'(bus_word(30'h1000_0040)));

        // Synchronous reset in the middle of a bus access.
        rdy_delay = 6;
        flush = 1'b1;
        new_pc = 30'h1000_0080;
        tick();
        flush = 1'b0;
        cyc = 0;
        while (if_bus_as_ && cyc < 30) begin tick(); cyc++; end
        check("t6r_in_access", 64'(if_bus_as_), 64'(0));
        reset = 1'b1;
        tick();
        check("t6r_outputs", 64'({if_en, if_pc, if_insn, busy}), 64'(0));
        check("t6r_strobes", 64'({if_bus_req_, if_bus_as_, if_spm_as_}), 64'(3'b111));
        reset = 1'b0;
        tick();
        check("t6r_bubble", 64'(if_en), 64'(0));
        tick();
        check("t6r_restart_en", 64'(if_en), 64'(1));
        check("t6r_restart_pc", 64'(if_pc), 64'(RV));

        // Random stall/flush traffic across SPM, bus and region boundaries.
        for (int c = 0; c < 3000; c++) begin
            tick();
            stall = ($urandom_range(0, 4) == 0);
            flush = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1;
                new_pc = pick_target();
                gnt_delay = $urandom_range(0, 4);
                rdy_delay = $urandom_range(0, 4);
            end
        end
        tick();
        stall = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 20; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and drives the IF port (port A) of the scratchpad memory.
- Fetches from the external bus through a request/grant/ready handshake when the PC is outside the SPM window.
- Delivers a registered {if_pc, if_insn, if_en} triple to the ID stage.
- Handles pipeline stall and flush/redirect from the CPU controller.

Parameters:
- ADDR_W, 30: word-address width.
- DATA_W, 32: instruction/data width.
- SPM_ADDR_W, 12: SPM word-address width (low bits of the PC).
- TAG_W, 3: region-select bits, PC[ADDR_W-1 -: TAG_W].
- SPM_TAG, 3'd1: tag value that selects the SPM.
- RESET_VECTOR, 30'h0800_0000: PC after reset (SPM region).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- stall  in  1  hold the IF/ID outputs and do not advance
- flush  in  1  redirect the PC to new_pc and discard in-flight fetches
- new_pc  in  ADDR_W  redirect target
- if_spm_addr  out  SPM_ADDR_W  SPM read address
- if_spm_as_  out  1  SPM address strobe, active-low
- if_spm_rw  out  1  constant READ
- if_spm_wr_data  out  DATA_W  constant 0
- if_spm_rd_data  in  DATA_W  SPM read data, valid 1 cycle after address
- if_bus_req_  out  1  bus request, active-low
- if_bus_grnt_  in  1  bus grant, active-low
- if_bus_addr  out  ADDR_W  bus address
- if_bus_as_  out  1  bus address strobe, active-low
- if_bus_rw  out  1  constant READ
- if_bus_rdy_  in  1  bus ready, active-low
- if_bus_rd_data  in  DATA_W  bus read data, valid when if_bus_rdy_=0
- if_pc  out  ADDR_W  word address of if_insn
- if_insn  out  DATA_W  fetched instruction
- if_en  out  1  if_insn valid this cycle
- busy  out  1  bus fetch in progress

Behaviour:
- Reset (sync, priority over everything):
  - fetch_pc=RESET_VECTOR; q1_valid=0; if_pc=0; if_insn=0 (NOP); if_en=0.
  - FSM=IDLE; busy=0.
  - if_bus_req_=if_bus_as_=1; if_spm_as_=1 during the reset cycle.
- Priority: reset > flush > stall.
- SPM path:
  - fetch_pc is in SPM if its tag==SPM_TAG.
  - Cycle N: if_spm_addr=fetch_pc[SPM_ADDR_W-1:0], if_spm_as_=0. At the edge: q1_pc<=fetch_pc, q1_valid<=1, fetch_pc<=fetch_pc+1.
  - Cycle N+1: if_spm_rd_data is valid. At the edge: if_insn<=rd_data, if_pc<=q1_pc, if_en<=1.
  - Latency 2 cycles from address issue to if_en. Throughput 1 per cycle.
  - fetch_pc wraps modulo 2^ADDR_W.
- Stall (no flush):
  - if_pc/if_insn/if_en hold; fetch_pc and q1 hold.
  - if_spm_addr=q1_pc (replay), so the RAM output keeps the in-flight word.
  - On release, the in-flight word is delivered first. No instruction is skipped or duplicated.
- Flush:
  - fetch_pc<=new_pc; q1_valid<=0; if_en<=0.
  - Any bus FSM state goes to IDLE with strobes deasserted next cycle; returned data is discarded.
  - First new instruction: if_en=1 two cycles after the flush cycle (SPM target).
- Bus path (fetch_pc tag != SPM_TAG):
  - The SPM pipeline drains first (q1 delivered); if_spm_as_=1.
  - FSM:
    - IDLE -> REQ: req_=0, busy=1.
    - REQ: wait grnt_=0 -> ACCESS.
    - ACCESS: as_=0, if_bus_addr=fetch_pc, req_ held 0. Wait rdy_=0.
    - On rdy_=0 with stall=0: if_insn<=bus data, if_pc<=fetch_pc, if_en<=1, fetch_pc+1, req_/as_<=1, go to IDLE.
    - On rdy_=0 with stall=1: latch data into bus_buf, go to DONE (strobes released). DONE: wait stall=0, then deliver as above and go to IDLE.
  - if_en=0 on every cycle without a newly delivered instruction (bubble).
  - busy=1 in REQ/ACCESS/DONE.
- Region change:
  - Sequential fetch crossing into the bus region: drain, then FSM.
  - Bus fetch returning to the SPM region: next cycle issues an SPM address.

Test Plan:
1. Release reset with RESET_VECTOR in SPM, SPM word k = 0xA000_0000+k -> if_en=1 from the 2nd cycle after release, if_pc=0x0800_0000, 0x0800_0001, … with matching insn every cycle.
2. stall high for 3 cycles mid-stream while pc 0x0800_0005 is in flight -> outputs frozen at 0x0800_0004. After release, 0x0800_0005 then 0x0800_0006 follow with no gap or repeat.
3. flush with new_pc=0x0800_0100 -> if_en=0 for 2 cycles, then if_pc=0x0800_0100 with correct insn. In-flight old words never appear.
4. flush to 0x1000_0000 (bus); grnt_ after 2 cycles, rdy_ 3 cycles after as_ with data 0xDEAD_BEEF -> busy=1 throughout. if_en pulses once with if_insn=0xDEAD_BEEF, if_pc=0x1000_0000. req_/as_ return to 1 the following cycle.
5. flush during ACCESS -> as_/req_ deassert next cycle. Late rdy_ data is ignored; the new target is fetched normally.
6. stall high when rdy_ asserts -> DONE holds the data; delivered only after stall drops. Sync reset asserted mid-ACCESS -> all outputs at reset values at the next edge, fetch restarts at RESET_VECTOR.
